// File: rtl/regdump_pkg.sv
// rtl/regdump_pkg.sv - default widths and state encoding shared by regfile_dump_ctrl
package regdump_pkg;

  localparam int REGDUMP_DW = 32;
  localparam int REGDUMP_AW = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_EMIT_S = 3'd2,
    ST_EMIT_T = 3'd3,
    ST_FILL   = 3'd4,
    ST_DONE   = 3'd5
  } regdump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - regfile32 dump streamer with optional pattern fill (REGDUMP_FILL_EN)
module regfile_dump_ctrl
  import regdump_pkg::*;
#(
  parameter int DW = REGDUMP_DW,
  parameter int AW = REGDUMP_AW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_mode,
  input  logic [DW-1:0] i_seed,
  output logic [AW-1:0] o_s_addr,
  output logic [AW-1:0] o_t_addr,
  input  logic [DW-1:0] i_s,
  input  logic [DW-1:0] i_t,
  output logic [DW-1:0] o_d,
  output logic          o_d_en,
  output logic [AW-1:0] o_d_addr,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [AW-1:0] o_out_addr,
  output logic [DW-1:0] o_out_data,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [AW-1:0] HALF      = {1'b1, {(AW-1){1'b0}}};
  localparam logic [AW-1:0] LAST_PAIR = {1'b0, {(AW-1){1'b1}}};

  regdump_state_t r_state;
  logic [AW-1:0]  r_idx;
  logic [AW-1:0]  r_s_addr;
  logic [AW-1:0]  r_t_addr;
  logic [DW-1:0]  r_buf_s;
  logic [DW-1:0]  r_buf_t;
  logic [AW-1:0]  w_idx_next;
  logic           w_emit_s;
  logic           w_emit_t;

`ifdef REGDUMP_FILL_EN
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
  logic [DW-1:0]  r_seed;
  logic [DW-1:0]  r_d;
  logic           r_d_en;
  logic [AW-1:0]  r_d_addr;
`endif

  assign w_idx_next = r_idx + AW'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_s_addr <= '0;
      r_t_addr <= '0;
      r_buf_s  <= '0;
      r_buf_t  <= '0;
`ifdef REGDUMP_FILL_EN
      r_seed   <= '0;
      r_d      <= '0;
      r_d_en   <= 1'b0;
      r_d_addr <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_mode) begin
            r_state  <= ST_READ;
            r_idx    <= '0;
            r_s_addr <= '0;
            r_t_addr <= HALF;
          end
`ifdef REGDUMP_FILL_EN
          else if (i_start) begin
            // first write goes out on the very next cycle, so preload index 0
            r_state  <= ST_FILL;
            r_idx    <= '0;
            r_seed   <= i_seed;
            r_d      <= i_seed;
            r_d_en   <= 1'b1;
            r_d_addr <= '0;
          end
`endif
        end
        ST_READ: begin
          r_buf_s <= i_s;
          r_buf_t <= i_t;
          r_state <= ST_EMIT_S;
        end
        ST_EMIT_S: begin
          if (i_out_ready) r_state <= ST_EMIT_T;
        end
        ST_EMIT_T: begin
          if (i_out_ready) begin
            if (r_idx == LAST_PAIR) begin
              r_state <= ST_DONE;
            end else begin
              r_idx    <= w_idx_next;
              r_s_addr <= w_idx_next;
              r_t_addr <= w_idx_next + HALF;
              r_state  <= ST_READ;
            end
          end
        end
`ifdef REGDUMP_FILL_EN
        ST_FILL: begin
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
            r_d_en  <= 1'b0;
          end else begin
            r_idx    <= w_idx_next;
            r_d_addr <= w_idx_next;
            r_d      <= r_seed + DW'(w_idx_next);
          end
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_emit_s    = (r_state == ST_EMIT_S);
  assign w_emit_t    = (r_state == ST_EMIT_T);
  assign o_out_valid = w_emit_s | w_emit_t;
  assign o_out_addr  = w_emit_s ? r_idx : (w_emit_t ? r_idx + HALF : '0);
  assign o_out_data  = w_emit_s ? r_buf_s : (w_emit_t ? r_buf_t : '0);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_s_addr    = r_s_addr;
  assign o_t_addr    = r_t_addr;

`ifdef REGDUMP_FILL_EN
  assign o_d      = r_d;
  assign o_d_en   = r_d_en;
  assign o_d_addr = r_d_addr;
`else
  logic w_unused_seed;
  assign w_unused_seed = ^i_seed;
  assign o_d      = '0;
  assign o_d_en   = 1'b0;
  assign o_d_addr = '0;
`endif

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - self-checking bench for regfile_dump_ctrl (fill checks under REGDUMP_FILL_EN)
module tb_regfile_dump_ctrl;

  localparam int N = 32;
  localparam int H = 16;

  logic        clk = 1'b0;
  logic        reset, start, mode, out_ready, pl_en;
  logic [31:0] seed;
  logic [4:0]  s_addr, t_addr, d_addr, out_addr;
  logic [31:0] s_data, t_data, d, out_data;
  logic        d_en, out_valid, busy, done;

  logic [31:0] mem [N];
  logic [31:0] exp_mem [N];

  int tests = 0;
  int fails = 0;

  logic [4:0]  cap_addr [$];
  logic [31:0] cap_data [$];
  int first_valid, last_word, done_cycle, done_count, busy_low, stall_bad;

  always #5 clk = ~clk;

  // regfile32 stand-in: combinational reads, posedge write, bulk preload
  assign s_data = mem[s_addr];
  assign t_data = mem[t_addr];
  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < N; i++) mem[i] <= exp_mem[i];
    end else if (d_en) begin
      mem[d_addr] <= d;
    end
  end

  regfile_dump_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_seed(seed),
    .o_s_addr(s_addr), .o_t_addr(t_addr), .i_s(s_data), .i_t(t_data),
    .o_d(d), .o_d_en(d_en), .o_d_addr(d_addr),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_addr(out_addr), .o_out_data(out_data),
    .o_busy(busy), .o_done(done)
  );

  task automatic preload();
    @(negedge clk);
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_dump(input bit toggle, input int inject_k);
    bit          held;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    cap_addr.delete();
    cap_data.delete();
    first_valid = -1; last_word = -1; done_cycle = -1; busy_low = -1;
    done_count = 0; stall_bad = 0; held = 0; h_addr = '0; h_data = '0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      start = (k == inject_k);
      if (k == inject_k) begin
        mode = 1'($urandom);
        seed = $urandom;
      end
      out_ready = toggle ? 1'(k % 2) : 1'b1;
      if (out_valid && first_valid < 0) first_valid = k;
      if (held && (!out_valid || out_addr !== h_addr || out_data !== h_data)) stall_bad++;
      held = 0;
      if (out_valid && out_ready) begin
        cap_addr.push_back(out_addr);
        cap_data.push_back(out_data);
        last_word = k;
      end else if (out_valid) begin
        held = 1; h_addr = out_addr; h_data = out_data;
      end
      if (done) begin
        done_count++;
        done_cycle = k;
      end
      if (!busy && done_count > 0) begin
        busy_low = k;
        break;
      end
    end
    start = 1'b0; mode = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; out_ready = 1'b1; pl_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({s_addr, t_addr, d, d_en, d_addr, out_valid, out_addr, out_data, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_values: got s=%0d t=%0d d=%h den=%b da=%0d v=%b oa=%0d od=%h busy=%b done=%b, expected all zero",
               s_addr, t_addr, d, d_en, d_addr, out_valid, out_addr, out_data, busy, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_dump();
    logic [4:0] ea;
    for (int i = 0; i < N; i++) exp_mem[i] = 32'hA000_0000 + i;
    preload();
    run_dump(1'b0, 0);
    tests++;
    if (cap_addr.size() != N) begin
      fails++; $display("FAIL dump_count: got %0d words, expected %0d", cap_addr.size(), N);
    end
    for (int j = 0; j < N; j++) begin
      ea = 5'((j % 2) ? j / 2 + H : j / 2);
      tests++;
      if (j >= cap_addr.size() || cap_addr[j] !== ea || cap_data[j] !== exp_mem[ea]) begin
        fails++;
        $display("FAIL dump_word[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                 j, (j < cap_addr.size()) ? cap_addr[j] : 5'd0, (j < cap_data.size()) ? cap_data[j] : 32'd0, ea, exp_mem[ea]);
      end
    end
    tests++;
    if (first_valid != 2) begin fails++; $display("FAIL dump_first_valid: got cycle %0d, expected 2", first_valid); end
    tests++;
    if (last_word != 48) begin fails++; $display("FAIL dump_last_word: got cycle %0d, expected 48", last_word); end
    tests++;
    if (done_cycle != 49 || done_count != 1) begin
      fails++; $display("FAIL dump_done: got cycle %0d count %0d, expected cycle 49 count 1", done_cycle, done_count);
    end
    tests++;
    if (busy_low != 50) begin fails++; $display("FAIL dump_busy_low: got cycle %0d, expected 50", busy_low); end
  endtask

  task automatic test_dump_stall();
    logic [4:0] ea;
    for (int i = 0; i < N; i++) exp_mem[i] = $urandom;
    preload();
    run_dump(1'b1, 0);
    tests++;
    if (cap_addr.size() != N) begin
      fails++; $display("FAIL stall_count: got %0d words, expected %0d", cap_addr.size(), N);
    end
    for (int j = 0; j < N; j++) begin
      ea = 5'((j % 2) ? j / 2 + H : j / 2);
      tests++;
      if (j >= cap_addr.size() || cap_addr[j] !== ea || cap_data[j] !== exp_mem[ea]) begin
        fails++;
        $display("FAIL stall_word[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                 j, (j < cap_addr.size()) ? cap_addr[j] : 5'd0, (j < cap_data.size()) ? cap_data[j] : 32'd0, ea, exp_mem[ea]);
      end
    end
    tests++;
    if (stall_bad != 0) begin fails++; $display("FAIL stall_hold: got %0d unstable stalled cycles, expected 0", stall_bad); end
    tests++;
    if (done_count != 1) begin fails++; $display("FAIL stall_done: got %0d done pulses, expected 1", done_count); end
  endtask

  task automatic test_reset_mid_dump();
    int s_words;
    s_words = 0;
    for (int i = 0; i < N; i++) exp_mem[i] = $urandom;
    preload();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_addr < 5'(H)) s_words++;
      if (s_words == 3) break;
    end
    tests++;
    if (s_words != 3) begin fails++; $display("FAIL reset_mid_reach: got %0d S words, expected 3", s_words); end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({s_addr, t_addr, d, d_en, d_addr, out_valid, out_addr, out_data, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_mid_values: got v=%b busy=%b oa=%0d od=%h s=%0d t=%0d, expected all zero",
               out_valid, busy, out_addr, out_data, s_addr, t_addr);
    end
    reset = 1'b0;
    run_dump(1'b0, 0);
    tests++;
    if (cap_addr.size() != N || cap_addr[0] !== 5'd0 || cap_data[0] !== exp_mem[0]) begin
      fails++;
      $display("FAIL reset_mid_restart: got %0d words first addr=%0d data=%h, expected %0d words addr=0 data=%h",
               cap_addr.size(), (cap_addr.size() > 0) ? cap_addr[0] : 5'd0, (cap_data.size() > 0) ? cap_data[0] : 32'd0, N, exp_mem[0]);
    end
  endtask

  task automatic test_start_while_busy();
    logic [4:0] ea;
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) exp_mem[i] = $urandom;
    preload();
    run_dump(1'b0, 10);
    for (int j = 0; j < N; j++) begin
      ea = 5'((j % 2) ? j / 2 + H : j / 2);
      if (j >= cap_addr.size() || cap_addr[j] !== ea || cap_data[j] !== exp_mem[ea]) bad++;
    end
    tests++;
    if (cap_addr.size() != N || bad != 0) begin
      fails++; $display("FAIL busy_start_seq: got %0d words %0d wrong, expected %0d words 0 wrong", cap_addr.size(), bad, N);
    end
    tests++;
    if (done_count != 1 || done_cycle != 49) begin
      fails++; $display("FAIL busy_start_done: got count %0d cycle %0d, expected count 1 cycle 49", done_count, done_cycle);
    end
  endtask

`ifdef REGDUMP_FILL_EN
  task automatic test_fill(input logic [31:0] s);
    int den_first, den_last, den_count, fdone, bad;
    logic [4:0] ea;
    den_first = -1; den_last = -1; den_count = 0; fdone = -1; bad = 0;
    for (int i = 0; i < N; i++) exp_mem[i] = s + 32'(i);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; seed = s;
    @(posedge clk);
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0; mode = 1'($urandom); seed = $urandom;
      if (d_en) begin
        if (den_first < 0) den_first = k;
        den_last = k;
        den_count++;
      end
      if (done) fdone = k;
      if (!busy && fdone > 0) break;
    end
    mode = 1'b0;
    tests++;
    if (den_first != 1 || den_last != 32 || den_count != 32) begin
      fails++; $display("FAIL fill_den: got first %0d last %0d count %0d, expected 1 32 32", den_first, den_last, den_count);
    end
    tests++;
    if (fdone != 33) begin fails++; $display("FAIL fill_done: got cycle %0d, expected 33", fdone); end
    for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL fill_contents: got %0d wrong registers, expected 0", bad); end
    run_dump(1'b0, 0);
    bad = 0;
    for (int j = 0; j < N; j++) begin
      ea = 5'((j % 2) ? j / 2 + H : j / 2);
      if (j >= cap_addr.size() || cap_addr[j] !== ea || cap_data[j] !== exp_mem[ea]) bad++;
    end
    tests++;
    if (cap_addr.size() != N || bad != 0) begin
      fails++; $display("FAIL fill_readback: got %0d words %0d wrong, expected %0d words 0 wrong", cap_addr.size(), bad, N);
    end
  endtask

  task automatic test_fill_wrap();
    test_fill(32'hFFFF_FFF0);
    tests++;
    if (mem[15] !== 32'hFFFF_FFFF || mem[16] !== 32'h0000_0000) begin
      fails++; $display("FAIL fill_wrap: got reg15=%h reg16=%h, expected ffffffff 00000000", mem[15], mem[16]);
    end
    test_fill($urandom);
  endtask
`else
  task automatic test_fill_disabled();
    int bad;
    bad = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; seed = $urandom;
    @(posedge clk);
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || d_en || done) bad++;
    end
    mode = 1'b0;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL fill_disabled: got %0d active cycles, expected 0", bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_dump();
    test_dump_stall();
    test_reset_mid_dump();
    test_start_while_busy();
`ifdef REGDUMP_FILL_EN
    test_fill_wrap();
`else
    test_fill_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Hardware sequencer that drives the initiator side of the `regfile32` port set: it scans all registers through the two read ports and streams each word out over a valid/ready interface. Optionally, it fills every register with a deterministic pattern through the write port. It sits between `regfile32` and a debug/trace sink, and replaces bench-only dump and write-pattern tasks with synthesizable logic.

## Interface
- `DW`, 32, data width of a register and of the stream.
- `AW`, 5, register address width; depth is 2**AW and half-depth is H = 2**(AW-1).
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request, sampled only in IDLE.
- `mode`  in  1  0 = dump, 1 = fill; sampled together with `start`.
- `seed`  in  DW  fill base value; sampled together with `start`.
- `S_Addr`  out  AW  read port S address (registered).
- `T_Addr`  out  AW  read port T address (registered).
- `S`  in  DW  read port S data, combinational from `S_Addr`.
- `T`  in  DW  read port T data, combinational from `T_Addr`.
- `D`  out  DW  write data (registered).
- `D_En`  out  1  write enable (registered).
- `D_Addr`  out  AW  write address (registered).
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  sink accepts the word.
- `out_addr`  out  AW  register index of the current word.
- `out_data`  out  DW  register contents.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at completion.

## Operation
- States: IDLE, READ, EMIT_S, EMIT_T, FILL, DONE. Index counter `idx` is AW bits wide.
- IDLE + `start` + `mode`=0: `idx`<=0, `S_Addr`<=0, `T_Addr`<=H, next state READ.
- READ: capture `S` into `buf_s` and `T` into `buf_t`; next state EMIT_S.
- EMIT_S: `out_valid`=1, `out_addr`=`idx`, `out_data`=`buf_s`. On `out_ready`, next state EMIT_T; otherwise hold all outputs stable.
- EMIT_T: `out_valid`=1, `out_addr`=`idx`+H, `out_data`=`buf_t`. On `out_ready`:
  - if `idx`==H-1, next state DONE;
  - else `idx`++, `S_Addr`<=`idx`+1, `T_Addr`<=`idx`+1+H, next state READ.
- Stream order: 0, H, 1, H+1, …, H-1, 2H-1.
- FILL: `D_En`=1, `D_Addr`=`idx`, `D`=`seed`+`idx`, with the sum truncated to DW bits (wraps). `idx` increments each cycle. Entry from IDLE sets `idx`=0. The write of index 2**AW-1 is followed by DONE.
- DONE: `done`=1, `D_En`=0, next state IDLE.
- `start` while `busy` is ignored. `mode`/`seed` changes while `busy` have no effect.
- `reset` in any state aborts immediately. No partial stream word remains valid after reset.

## Timing
- Reset values: `S_Addr`=0, `T_Addr`=0, `D`=0, `D_En`=0, `D_Addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `busy`=0, `done`=0, state=IDLE.
- Dump, `start` sampled at edge 0 with `out_ready` held high:
  - first `out_valid` in cycle 2;
  - one READ plus two EMIT cycles per pair;
  - last word in cycle 48, `done` in cycle 49, `busy` low from cycle 50.
- Each `out_ready` low cycle adds exactly one cycle of latency.
- Fill: `D_En` high in cycles 1..32, `done` in cycle 33.
- A stream word transfers only on a cycle where `out_valid`&&`out_ready`.

## Configuration
- `REGDUMP_FILL_EN` defined: fill mode and the `seed` path are present, as described above.
- `REGDUMP_FILL_EN` undefined: FILL state is removed. `start` with `mode`=1 is ignored and the block stays in IDLE. `D`, `D_En` and `D_Addr` are tied to 0. `seed` is unused.

## Structure
- Package `regdump_pkg` holds:
  - the state enum `regdump_state_t`;
  - default `DW`/`AW` constants.
- Single module; no sub-module is natural.

## Test plan
- Preload reg[i]=32'hA000_0000+i, dump with `out_ready`=1 -> 32 words in order 0,16,1,17,…,15,31, each data matching; `done` in cycle 49.
- Same preload, `out_ready` toggling 1,0 -> identical sequence, words held stable while stalled, no drop or duplicate.
- Fill with `seed`=32'hFFFF_FFF0 -> reg[15]=32'hFFFF_FFFF, reg[16]=0 (wrap); a following dump reads back the filled values.
- Assert `reset` at the third EMIT_S of a dump -> next cycle: `out_valid`=0, `busy`=0, all outputs at reset values. A new `start` then begins at index 0.
- Pulse `start` during a dump -> ignored; exactly 32 words and one `done`.
- Build without `REGDUMP_FILL_EN`, `start` with `mode`=1 -> `busy` stays 0, `D_En` stays 0.
